// File: rtl/trace_frame_pkg.sv
// Shared types and default sizing for the capture-record UART framer.
package trace_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_TRD,
        S_GAP,
        S_FIN
    } state_t;

    typedef enum logic [2:0] {
        SEG_HDR,
        SEG_PT,
        SEG_KEY,
        SEG_CT,
        SEG_TRC,
        SEG_CSUM
    } seg_t;

    localparam logic [7:0] DEF_HDR_BYTE   = 8'hA5;
    localparam int         DEF_BLOCK_SIZE = 64;
    localparam int         DEF_KEY_SIZE   = 80;
    localparam int         DEF_SAMPLES    = 1024;

    localparam int PT_BYTES    = DEF_BLOCK_SIZE / 8;
    localparam int KEY_BYTES   = DEF_KEY_SIZE / 8;
    localparam int CT_BYTES    = DEF_BLOCK_SIZE / 8;
    localparam int FRAME_BYTES = 1 + PT_BYTES + KEY_BYTES + CT_BYTES + DEF_SAMPLES + 1;

endpackage

// File: rtl/frame_byte_mux.sv
// Picks the outgoing byte of a register-field segment, MSB byte first.
module frame_byte_mux
    import trace_frame_pkg::*;
#(
    parameter int         BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int         KEY_SIZE   = DEF_KEY_SIZE,
    parameter int         IDX_W      = 11,
    parameter logic [7:0] HDR_BYTE   = DEF_HDR_BYTE
) (
    input  logic [2:0]            seg,
    input  logic [IDX_W-1:0]      idx,
    input  logic [BLOCK_SIZE-1:0] pt,
    input  logic [KEY_SIZE-1:0]   key,
    input  logic [BLOCK_SIZE-1:0] ct,
    output logic [7:0]            byte_out
);
    localparam int N_PT  = BLOCK_SIZE / 8;
    localparam int N_KEY = KEY_SIZE / 8;

    always_comb begin
        byte_out = 8'h00;
        case (seg)
            SEG_HDR: byte_out = HDR_BYTE;
            SEG_PT: begin
                for (int i = 0; i < N_PT; i++)
                    if (idx == IDX_W'(i)) byte_out = pt[(N_PT-1-i)*8 +: 8];
            end
            SEG_KEY: begin
                for (int i = 0; i < N_KEY; i++)
                    if (idx == IDX_W'(i)) byte_out = key[(N_KEY-1-i)*8 +: 8];
            end
            SEG_CT: begin
                for (int i = 0; i < N_PT; i++)
                    if (idx == IDX_W'(i)) byte_out = ct[(N_PT-1-i)*8 +: 8];
            end
            default: byte_out = 8'h00;
        endcase
    end

endmodule

// File: rtl/trace_frame_tx.sv
// Frames one capture record (header, pt, key, ct, trace, XOR checksum) onto uart_tx,
// followed by a programmable settle gap.
module trace_frame_tx
    import trace_frame_pkg::*;
#(
    parameter int         BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int         KEY_SIZE   = DEF_KEY_SIZE,
    parameter int         SAMPLES    = DEF_SAMPLES,
    parameter int         ADDR_W     = 10,
    parameter logic [7:0] HDR_BYTE   = DEF_HDR_BYTE,
    parameter int         GAP_W      = 13
) (
    input  logic                  clk,
    input  logic                  c10_resetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [GAP_W-1:0]      gap_cycles,
    input  logic [BLOCK_SIZE-1:0] pt,
    input  logic [KEY_SIZE-1:0]   key,
    input  logic [BLOCK_SIZE-1:0] ct,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_en,
    input  logic [7:0]            rd_data,
    output logic                  tx_dv,
    output logic [7:0]            tx_byte,
    input  logic                  tx_done,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            checksum
);
    localparam int N_PT  = BLOCK_SIZE / 8;
    localparam int N_KEY = KEY_SIZE / 8;
    // One extra bit over the trace address so a full 2^ADDR_W trace never wraps.
    localparam int IDX_W = (ADDR_W + 1 > 8) ? ADDR_W + 1 : 8;

    state_t                state, state_nxt;
    seg_t                  seg, seg_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic                  last_in_seg;
    logic [BLOCK_SIZE-1:0] pt_q, ct_q;
    logic [KEY_SIZE-1:0]   key_q;
    logic [GAP_W-1:0]      gap_q, gap_cnt;
    logic [7:0]            csum_run;
    logic [7:0]            mux_byte;

    frame_byte_mux #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .KEY_SIZE   (KEY_SIZE),
        .IDX_W      (IDX_W),
        .HDR_BYTE   (HDR_BYTE)
    ) u_mux (
        .seg      (seg),
        .idx      (idx),
        .pt       (pt_q),
        .key      (key_q),
        .ct       (ct_q),
        .byte_out (mux_byte)
    );

    always_comb begin
        last_in_seg = 1'b1;
        case (seg)
            SEG_PT, SEG_CT: last_in_seg = (idx == IDX_W'(N_PT - 1));
            SEG_KEY:        last_in_seg = (idx == IDX_W'(N_KEY - 1));
            SEG_TRC:        last_in_seg = (idx == IDX_W'(SAMPLES - 1));
            default:        last_in_seg = 1'b1;
        endcase
        seg_nxt = seg;
        idx_nxt = idx + IDX_W'(1);
        if (last_in_seg) begin
            idx_nxt = '0;
            case (seg)
                SEG_HDR: seg_nxt = SEG_PT;
                SEG_PT:  seg_nxt = SEG_KEY;
                SEG_KEY: seg_nxt = SEG_CT;
                SEG_CT:  seg_nxt = SEG_TRC;
                default: seg_nxt = SEG_CSUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge c10_resetn) begin
        if (!c10_resetn) state <= S_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) state_nxt = S_LOAD;
                S_LOAD: state_nxt = S_WAIT;
                S_WAIT: begin
                    if (tx_done) begin
                        if (seg == SEG_CSUM)
                            state_nxt = (gap_q == '0) ? S_FIN : S_GAP;
                        else if (seg_nxt == SEG_TRC)
                            state_nxt = S_TRD;
                        else
                            state_nxt = S_LOAD;
                    end
                end
                S_TRD:  state_nxt = S_LOAD;
                S_GAP:  if (gap_cnt == '0) state_nxt = S_FIN;
                S_FIN:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge c10_resetn) begin
        if (!c10_resetn) begin
            pt_q     <= '0;
            key_q    <= '0;
            ct_q     <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
            csum_run <= 8'h00;
            checksum <= 8'h00;
            tx_byte  <= 8'h00;
            tx_dv    <= 1'b0;
            seg      <= SEG_HDR;
            idx      <= '0;
        end else begin
            tx_dv <= 1'b0;
            if (!abort) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            pt_q     <= pt;
                            key_q    <= key;
                            ct_q     <= ct;
                            gap_q    <= gap_cycles;
                            csum_run <= 8'h00;
                            seg      <= SEG_HDR;
                            idx      <= '0;
                        end
                    end
                    S_LOAD: begin
                        tx_dv <= 1'b1;
                        // Trace bytes arrive from memory this cycle, the rest are held locally.
                        if (seg == SEG_TRC) begin
                            tx_byte <= rd_data;
                        end else if (seg == SEG_CSUM) begin
                            tx_byte  <= csum_run;
                            checksum <= csum_run;
                        end else begin
                            tx_byte <= mux_byte;
                        end
                    end
                    S_WAIT: begin
                        if (tx_done) begin
                            if (seg != SEG_HDR && seg != SEG_CSUM)
                                csum_run <= csum_run ^ tx_byte;
                            seg <= seg_nxt;
                            idx <= idx_nxt;
                            if (seg == SEG_CSUM) gap_cnt <= gap_q - GAP_W'(1);
                        end
                    end
                    S_GAP: gap_cnt <= gap_cnt - GAP_W'(1);
                    default: ;
                endcase
            end
        end
    end

    assign busy    = (state != S_IDLE) && (state != S_FIN);
    assign done    = (state == S_FIN);
    assign rd_en   = (state == S_TRD);
    assign rd_addr = rd_en ? idx[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_trace_frame_tx.sv
// Bench for trace_frame_tx: uart/memory models, table vectors, random frames, corner sequences.
module tb_trace_frame_tx;
    localparam int NS    = 1024;
    localparam int FRAME = 1052;

    logic        clk, c10_resetn, start, abort;
    logic [12:0] gap_cycles;
    logic [63:0] pt, ct;
    logic [79:0] key;
    logic [9:0]  rd_addr;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_done;
    logic        busy, done;
    logic [7:0]  checksum;

    trace_frame_tx dut (
        .clk        (clk),
        .c10_resetn (c10_resetn),
        .start      (start),
        .abort      (abort),
        .gap_cycles (gap_cycles),
        .pt         (pt),
        .key        (key),
        .ct         (ct),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .tx_dv      (tx_dv),
        .tx_byte    (tx_byte),
        .tx_done    (tx_done),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:NS-1];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    typedef struct {
        logic [63:0] pt;
        logic [79:0] key;
        logic [63:0] ct;
        int          gap;
        int          dly;
        logic [7:0]  csum;
    } vec_t;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, uart_cnt = 0, uart_delay = 10;
    int done_cnt, done_cyc, last_done_cyc, rd_cnt, rd_bad, rd_exp, stab_bad, early_dv;
    logic       prev_rd = 1'b0;
    logic [7:0] dv_byte = 8'h00, exp_csum, last_csum = 8'h00;
    logic [7:0] cap[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    // One clock: sample DUT at negedge, run uart_tx model and read-port bookkeeping.
    task automatic step();
        logic prev_done;
        @(negedge clk);
        cyc++;
        prev_done = tx_done;
        tx_done = 1'b0;
        if (tx_dv) begin
            if (uart_cnt > 0 || prev_done) early_dv++;
            cap.push_back(tx_byte);
            dv_byte = tx_byte;
        end else if (uart_cnt > 0 && tx_byte !== dv_byte) begin
            stab_bad++;
        end
        if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) begin
                tx_done = 1'b1;
                last_done_cyc = cyc;
            end
        end
        if (tx_dv) uart_cnt = uart_delay;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rd_en) begin
            rd_cnt++;
            if (rd_addr !== 10'(rd_exp) || prev_rd) rd_bad++;
            rd_exp++;
        end
        prev_rd = rd_en;
    endtask

    // Reference frame built straight from the record layout.
    task automatic build_expected(input logic [63:0] p, input logic [79:0] k, input logic [63:0] c);
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 8; i++)  exp_q.push_back(p[63-8*i -: 8]);
        for (int i = 0; i < 10; i++) exp_q.push_back(k[79-8*i -: 8]);
        for (int i = 0; i < 8; i++)  exp_q.push_back(c[63-8*i -: 8]);
        for (int i = 0; i < NS; i++) exp_q.push_back(mem[i]);
        x = 8'h00;
        for (int i = 1; i < exp_q.size(); i++) x ^= exp_q[i];
        exp_q.push_back(x);
        exp_csum = x;
    endtask

    task automatic begin_frame(input string tag, input logic [63:0] p, input logic [79:0] k,
                               input logic [63:0] c, input int gap, input int dly);
        build_expected(p, k, c);
        uart_delay = dly;
        cap.delete();
        done_cnt = 0; rd_cnt = 0; rd_bad = 0; rd_exp = 0; stab_bad = 0; early_dv = 0;
        pt = p; key = k; ct = c; gap_cycles = 13'(gap);
        start = 1'b1;
        step();
        start = 1'b0;
        pt = {$urandom, $urandom};
        ct = {$urandom, $urandom};
        key = {$urandom, $urandom, 16'h5a5a};
        gap_cycles = 13'h1abc;
        chk({tag, "_busy_rise"}, 64'(busy), 1);
    endtask

    task automatic wait_done(input string tag, input bit inject);
        int  k = 0;
        bit  inj_a = 0, inj_b = 0;
        while (done_cnt == 0 && k < 20000) begin
            start = 1'b0;
            if (inject && !inj_a && cap.size() == 5)   begin start = 1'b1; inj_a = 1; end
            if (inject && !inj_b && cap.size() == 600) begin start = 1'b1; inj_b = 1; end
            step();
            k++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(done_cnt > 0), 1);
        repeat (5) step();
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int k = 0;
        while (cap.size() < n && k < 5000) begin
            step();
            k++;
        end
        chk({tag, "_reach"}, 64'(cap.size() >= n), 1);
    endtask

    task automatic check_frame(input string tag, input int gap, input logic [7:0] csum_req);
        int bad = 0;
        chk({tag, "_len"}, 64'(cap.size()), FRAME);
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            if (cap[i] !== exp_q[i]) bad++;
        chk({tag, "_bytes_bad"}, 64'(bad), 0);
        chk({tag, "_csum_out"}, 64'(checksum), 64'(csum_req));
        chk({tag, "_csum_byte"}, 64'((cap.size() > 0) ? cap[cap.size()-1] : 8'h00), 64'(csum_req));
        chk({tag, "_done_cnt"}, 64'(done_cnt), 1);
        chk({tag, "_busy_low"}, 64'(busy), 0);
        chk({tag, "_done_lat"}, 64'(done_cyc - last_done_cyc), 64'(gap + 1));
        chk({tag, "_rd_cnt"}, 64'(rd_cnt), NS);
        chk({tag, "_rd_bad"}, 64'(rd_bad), 0);
        chk({tag, "_stable"}, 64'(stab_bad + early_dv), 0);
        last_csum = csum_req;
    endtask

    initial begin
        vec_t        vecs[4];
        logic [95:0] r96;
        int          n_dv, busy_seen;

        vecs[0] = '{64'h0123456789ABCDEF, 80'h3b6a8cf71e295d0b4f2e, 64'hFEDCBA9876543210, 0, 10, 8'h2A};
        vecs[1] = '{64'h0, 80'h0, 64'h0, 100, 2, 8'h00};
        vecs[2] = '{64'hFF00000000000000, 80'h0, 64'h0, 3, 1, 8'hFF};
        vecs[3] = '{64'h8000000000000001, 80'h1, 64'h1, 0, 3, 8'h81};

        c10_resetn = 1'b0; start = 1'b0; abort = 1'b0; tx_done = 1'b0;
        gap_cycles = '0; pt = '0; key = '0; ct = '0;
        for (int i = 0; i < NS; i++) mem[i] = 8'(i);
        repeat (3) step();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_tx_dv", 64'(tx_dv), 0);
        chk("rst_tx_byte", 64'(tx_byte), 0);
        chk("rst_rd_en", 64'(rd_en), 0);
        chk("rst_rd_addr", 64'(rd_addr), 0);
        chk("rst_checksum", 64'(checksum), 0);
        c10_resetn = 1'b1;
        repeat (2) step();

        for (int v = 0; v < 4; v++) begin
            begin_frame($sformatf("vec%0d", v), vecs[v].pt, vecs[v].key, vecs[v].ct, vecs[v].gap, vecs[v].dly);
            wait_done($sformatf("vec%0d", v), 0);
            check_frame($sformatf("vec%0d", v), vecs[v].gap, vecs[v].csum);
        end

        // start pulses while busy are dropped
        begin_frame("busy_start", vecs[0].pt, vecs[0].key, vecs[0].ct, 0, 2);
        wait_done("busy_start", 1);
        check_frame("busy_start", 0, vecs[0].csum);

        // abort and start together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("abort_vs_start_busy", 64'(busy), 0);

        // abort mid-key, then a clean frame
        begin_frame("abort", vecs[3].pt, vecs[3].key, vecs[3].ct, 0, 2);
        wait_bytes("abort", 12);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 0);
        chk("abort_tx_dv", 64'(tx_dv), 0);
        chk("abort_done", 64'(done), 0);
        chk("abort_rd_en", 64'(rd_en), 0);
        chk("abort_csum_hold", 64'(checksum), 64'(last_csum));
        n_dv = cap.size();
        busy_seen = 0;
        repeat (30) begin
            step();
            if (busy) busy_seen++;
        end
        chk("abort_quiet_dv", 64'(cap.size() - n_dv), 0);
        chk("abort_quiet_busy", 64'(busy_seen), 0);
        chk("abort_quiet_done", 64'(done_cnt), 0);
        begin_frame("post_abort", vecs[0].pt, vecs[0].key, vecs[0].ct, 0, 2);
        wait_done("post_abort", 0);
        check_frame("post_abort", 0, vecs[0].csum);

        // random records and trace contents against the reference frame
        for (int r = 0; r < 2; r++) begin
            logic [63:0] rp, rc;
            int          rg, rdl;
            for (int i = 0; i < NS; i++) mem[i] = 8'($urandom);
            rp  = {$urandom, $urandom};
            rc  = {$urandom, $urandom};
            r96 = {$urandom, $urandom, $urandom};
            rg  = $urandom_range(0, 20);
            rdl = $urandom_range(1, 5);
            begin_frame($sformatf("rnd%0d", r), rp, r96[79:0], rc, rg, rdl);
            wait_done($sformatf("rnd%0d", r), 0);
            check_frame($sformatf("rnd%0d", r), rg, exp_csum);
        end

        // async reset while waiting on a trace byte
        begin_frame("arst", vecs[0].pt, vecs[0].key, vecs[0].ct, 0, 4);
        wait_bytes("arst", 32);
        step();
        c10_resetn = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 0);
        chk("arst_done", 64'(done), 0);
        chk("arst_tx_dv", 64'(tx_dv), 0);
        chk("arst_tx_byte", 64'(tx_byte), 0);
        chk("arst_rd_en", 64'(rd_en), 0);
        chk("arst_rd_addr", 64'(rd_addr), 0);
        chk("arst_checksum", 64'(checksum), 0);
        uart_cnt = 0;
        tx_done = 1'b0;
        repeat (2) step();
        c10_resetn = 1'b1;
        n_dv = cap.size();
        busy_seen = 0;
        repeat (30) begin
            step();
            if (busy) busy_seen++;
        end
        chk("arst_quiet_dv", 64'(cap.size() - n_dv), 0);
        chk("arst_quiet_busy", 64'(busy_seen), 0);
        begin_frame("arst_restart", vecs[0].pt, vecs[0].key, vecs[0].ct, 0, 2);
        wait_bytes("arst_restart", 2);
        chk("arst_restart_hdr", 64'(cap[0]), 64'h A5);
        chk("arst_restart_pt0", 64'(cap[1]), 64'h01);
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
